// File: rtl/prog_timer_if.sv
// Configuration handshake bundle for prog_timer: valid/ready plus the limit,
// prescale, direction and mode fields that are latched on acceptance.
interface prog_timer_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_max;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_down;
    logic             cfg_oneshot;

    modport master (
        output cfg_valid,
        output cfg_max,
        output cfg_div,
        output cfg_down,
        output cfg_oneshot,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_max,
        input  cfg_div,
        input  cfg_down,
        input  cfg_oneshot,
        output cfg_ready
    );
endinterface

// File: rtl/prog_timer.sv
// Programmable timer: runtime limit, prescaler, up/down, periodic or one-shot.
// Optional sticky interrupt with PROG_TIMER_IRQ_EN defined.
module prog_timer #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             stop,
    prog_timer_if.slave      cfg,
    output logic [WIDTH-1:0] count,
    output logic             tick,
`ifdef PROG_TIMER_IRQ_EN
    output logic             irq,
    input  logic             irq_clr,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] max_q;
    logic [DIV_W-1:0] div_q;
    logic             down_q;
    logic             oneshot_q;
    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] presc_next;
    logic [WIDTH-1:0] count_next;
    logic             tick_next;
    logic             accept;
    logic             at_terminal;

    assign cfg.cfg_ready = (state != RUN);
    assign busy          = (state == RUN);
    assign accept        = cfg.cfg_valid && (state != RUN);
    assign at_terminal   = down_q ? (count == '0) : (count == max_q);

    // Only a step taken below the terminal moves the count, so +1/-1 never wraps.
    always_comb begin
        state_next = state;
        presc_next = presc;
        count_next = count;
        tick_next  = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = RUN;
                    presc_next = '0;
                    count_next = cfg.cfg_down ? cfg.cfg_max : '0;
                end else if (stop) begin
                    state_next = IDLE;
                    presc_next = '0;
                    count_next = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                    presc_next = '0;
                    count_next = '0;
                end else if (en) begin
                    if (presc == div_q) begin
                        presc_next = '0;
                        if (at_terminal) begin
                            tick_next = 1'b1;
                            if (oneshot_q) begin
                                state_next = DONE;
                            end else begin
                                count_next = down_q ? max_q : '0;
                            end
                        end else if (down_q) begin
                            count_next = count - WIDTH'(1);
                        end else begin
                            count_next = count + WIDTH'(1);
                        end
                    end else begin
                        presc_next = presc + DIV_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                presc_next = '0;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            tick  <= 1'b0;
            presc <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            tick  <= tick_next;
            presc <= presc_next;
        end
    end

    // Configuration is only sampled on an accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_q     <= '0;
            div_q     <= '0;
            down_q    <= 1'b0;
            oneshot_q <= 1'b0;
        end else if (accept) begin
            max_q     <= cfg.cfg_max;
            div_q     <= cfg.cfg_div;
            down_q    <= cfg.cfg_down;
            oneshot_q <= cfg.cfg_oneshot;
        end
    end

`ifdef PROG_TIMER_IRQ_EN
    // A tick being produced at this edge outranks any clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else if (tick_next) begin
            irq <= 1'b1;
        end else if (accept || irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer: a per-cycle vector table plus directed
// sequences for reset, the full-range one-shot and the optional interrupt.
module tb_prog_timer;

    logic       clk;
    logic       rst;
    logic       en;
    logic       stop;
    logic [7:0] count;
    logic       tick;
    logic       busy;
`ifdef PROG_TIMER_IRQ_EN
    logic       irq;
    logic       irq_clr;
`endif

    int checks;
    int errors;

    prog_timer_if #(.WIDTH(8), .DIV_W(8)) cfg_bus ();

    prog_timer #(.WIDTH(8), .DIV_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .stop    (stop),
        .cfg     (cfg_bus),
        .count   (count),
        .tick    (tick),
`ifdef PROG_TIMER_IRQ_EN
        .irq     (irq),
        .irq_clr (irq_clr),
`endif
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] max;
        logic [7:0] div;
        logic       down;
        logic       oneshot;
        logic       en;
        logic       stop;
        logic [7:0] exp_count;
        logic       exp_tick;
        logic       exp_busy;
        logic       exp_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [7:0] m, logic [7:0] d, logic dn, logic os,
                                logic e, logic s, logic [7:0] c, logic t, logic b, logic r);
        vec_t x;
        x.valid = v;  x.max = m;  x.div = d;  x.down = dn;  x.oneshot = os;
        x.en = e;     x.stop = s;
        x.exp_count = c;  x.exp_tick = t;  x.exp_busy = b;  x.exp_ready = r;
        return x;
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [7:0] m, input logic [7:0] d,
                                  input logic dn, input logic os, input logic e, input logic s);
        cfg_bus.cfg_valid   = v;
        cfg_bus.cfg_max     = m;
        cfg_bus.cfg_div     = d;
        cfg_bus.cfg_down    = dn;
        cfg_bus.cfg_oneshot = os;
        en   = e;
        stop = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int c, input int t, input int b, input int r);
        check_output({tag, " count"}, int'(count), c);
        check_output({tag, " tick"}, int'(tick), t);
        check_output({tag, " busy"}, int'(busy), b);
        check_output({tag, " ready"}, int'(cfg_bus.cfg_ready), r);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
`ifdef PROG_TIMER_IRQ_EN
        irq_clr = 1'b0;
`endif
        apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("por", 0, 0, 0, 1);
        rst = 1'b0;

        // Up periodic M=3 D=0; a config offered mid-run must be ignored
        vecs.push_back(mk(1, 3, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0, 1, 0, 2, 0, 1, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0, 1, 0, 3, 0, 1, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 9, 2, 1, 1, 1, 0, 2, 0, 1, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0, 1, 0, 3, 0, 1, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        // Down one-shot M=2 D=1
        vecs.push_back(mk(1, 2, 1, 1, 1, 1, 0, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        // en gating, M=4 D=0 up periodic
        vecs.push_back(mk(1, 4, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 3, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        // stop colliding with a terminal step, M=1 D=0 periodic
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        // cfg_valid and stop together in IDLE: config wins
        vecs.push_back(mk(1, 2, 0, 0, 0, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        // Up one-shot M=1: DONE holds the terminal, stop returns to zero
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        // M=0 periodic: tick on every step
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        // M=0 down one-shot D=2: DONE after the first step
        vecs.push_back(mk(1, 0, 2, 1, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].valid, vecs[i].max, vecs[i].div, vecs[i].down,
                           vecs[i].oneshot, vecs[i].en, vecs[i].stop);
            check_all($sformatf("vec%0d", i), int'(vecs[i].exp_count), int'(vecs[i].exp_tick),
                      int'(vecs[i].exp_busy), int'(vecs[i].exp_ready));
        end

        // Reset held for two cycles in the middle of a run
        apply_stimulus(1'b1, 8'd5, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_all("prerst", 2, 0, 1, 0);
        rst = 1'b1;
        apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_all("midrst", 0, 0, 0, 1);
        rst = 1'b0;
        apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_all("postrst", 0, 0, 0, 1);

        // Full range one-shot: 256 steps up to 255 with no overflow
        apply_stimulus(1'b1, 8'd255, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_all("wide0", 0, 0, 1, 0);
        for (int i = 1; i <= 255; i++) begin
            apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            check_output($sformatf("wide%0d count", i), int'(count), i);
            check_output($sformatf("wide%0d tick", i), int'(tick), 0);
        end
        apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_all("wideterm", 255, 1, 0, 1);
        apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_all("widehold", 255, 0, 0, 1);

`ifdef PROG_TIMER_IRQ_EN
        check_output("irq sticky", int'(irq), 1);
        irq_clr = 1'b1;
        apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        irq_clr = 1'b0;
        check_output("irq cleared", int'(irq), 0);
        apply_stimulus(1'b1, 8'd1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_output("irq idle", int'(irq), 0);
        irq_clr = 1'b1;
        apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        irq_clr = 1'b0;
        check_output("irq tick", int'(tick), 1);
        check_output("irq set beats clr", int'(irq), 1);
        apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_output("irq after stop", int'(irq), 1);
        apply_stimulus(1'b1, 8'd3, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_output("irq accept clr", int'(irq), 0);
        apply_stimulus(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
